// File: rtl/seq_magnitude_cmp_pkg.sv
// Shared Mini-ALU compare definitions: relational op codes, FSM states and
// the flag-to-result mapping.
package seq_magnitude_cmp_pkg;

  localparam logic [2:0] CMP_EQ = 3'd0;
  localparam logic [2:0] CMP_NE = 3'd1;
  localparam logic [2:0] CMP_LT = 3'd2;
  localparam logic [2:0] CMP_LE = 3'd3;
  localparam logic [2:0] CMP_GT = 3'd4;
  localparam logic [2:0] CMP_GE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // Reserved op codes (6, 7) always evaluate false.
  function automatic logic apply_op(input logic [2:0] op, input logic gt,
                                    input logic eq, input logic lt);
    logic r;
    case (op)
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_magnitude_cmp_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-wide slice of A against B.
module seq_magnitude_cmp_chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             eq
);

  assign gt = (x > y);
  assign eq = (x == y);

endmodule

// File: rtl/seq_magnitude_cmp.sv
// Multi-cycle magnitude comparator: scans operands CHUNK bits per cycle,
// most significant chunk first, and reports gt/eq/lt plus an op result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | in_ready high; capture operands and op on in_valid
// ST_RUN  | compare chunk idx; idx counts down from NCHUNK-1 to 0
// ST_DONE | out_valid high, flags/result stable until out_ready
module seq_magnitude_cmp
  import seq_magnitude_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             result
);

  // WIDTH must be an integer multiple of CHUNK.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  cmp_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [IDXW-1:0]  idx;
  logic             dir_gt;
  logic             dir_lt;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic             c_gt;
  logic             c_eq;
  logic             last;
  logic             found;
  logic             cur_gt;
  logic             cur_lt;
  logic             stop;

  for (genvar g = 0; g < NCHUNK; g++) begin : g_split
    assign a_chunk[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunk[g] = b_q[g*CHUNK +: CHUNK];
  end

  seq_magnitude_cmp_chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .x  (a_chunk[idx]),
    .y  (b_chunk[idx]),
    .gt (c_gt),
    .eq (c_eq)
  );

  assign in_ready = (state == ST_IDLE);

  // Decide the running direction: the first unequal chunk wins, later chunks
  // only matter while everything above them has compared equal.
  always_comb begin
    last   = (idx == '0);
    found  = dir_gt | dir_lt;
    cur_gt = found ? dir_gt : c_gt;
    cur_lt = found ? dir_lt : ~(c_gt | c_eq);
    stop   = last | (EARLY_EXIT & ~c_eq);
  end

  // Control FSM with index down-counter and registered flags/result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx       <= '0;
      dir_gt    <= 1'b0;
      dir_lt    <= 1'b0;
      out_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      result    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit maps two's complement onto unsigned order.
            a_q    <= is_signed ? (a ^ MSB_MASK) : a;
            b_q    <= is_signed ? (b ^ MSB_MASK) : b;
            op_q   <= op;
            idx    <= IDXW'(NCHUNK - 1);
            dir_gt <= 1'b0;
            dir_lt <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            a_gt_b    <= cur_gt;
            a_lt_b    <= cur_lt;
            a_eq_b    <= ~(cur_gt | cur_lt);
            result    <= apply_op(op_q, cur_gt, ~(cur_gt | cur_lt), cur_lt);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            dir_gt <= cur_gt;
            dir_lt <= cur_lt;
            idx    <= idx - IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_cmp.sv
// Scoreboard bench: drives an early-exit and a fixed-latency instance with the
// same operands and checks both against an integer reference model.
module tb_seq_magnitude_cmp;
  import seq_magnitude_cmp_pkg::*;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       is_signed = 1'b0;
  logic [2:0] op = '0;
  logic       out_ready = 1'b1;

  logic [1:0] in_ready, ov, gt, eq, lt, res;

  always #5 clk = ~clk;

  seq_magnitude_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .is_signed(is_signed), .op(op),
    .out_valid(ov[0]), .out_ready(out_ready),
    .a_gt_b(gt[0]), .a_eq_b(eq[0]), .a_lt_b(lt[0]), .result(res[0]));

  seq_magnitude_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .is_signed(is_signed), .op(op),
    .out_valid(ov[1]), .out_ready(out_ready),
    .a_gt_b(gt[1]), .a_eq_b(eq[1]), .a_lt_b(lt[1]), .result(res[1]));

  typedef struct {
    logic gt, eq, lt, res;
    int   lat;
    int   t_acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   seen[2];
  bit   mon_got;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cmp = 0;
  bit   hold_low = 1'b0;
  bit   rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer compare; latency = chunks down to the
  // highest differing bit (all chunks when equal).
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic s, input logic [2:0] iop);
    exp_t m;
    int va, vb;
    logic [7:0] d;
    bit found;
    va = int'(ia);
    vb = int'(ib);
    if (s && ia[7]) va = va - 256;
    if (s && ib[7]) vb = vb - 256;
    m.gt = (va > vb);
    m.eq = (va == vb);
    m.lt = (va < vb);
    case (iop)
      3'd0:    m.res = m.eq;
      3'd1:    m.res = !m.eq;
      3'd2:    m.res = m.lt;
      3'd3:    m.res = m.lt || m.eq;
      3'd4:    m.res = m.gt;
      3'd5:    m.res = m.gt || m.eq;
      default: m.res = 1'b0;
    endcase
    d = ia ^ ib;
    m.lat = NCHUNK;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        found = 1'b1;
        m.lat = NCHUNK - i / CHUNK;
      end
    end
    m.t_acc = 0;
    return m;
  endfunction

  always @(posedge clk) begin
    #2;
    if (hold_low)     out_ready = 1'b0;
    else if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    else              out_ready = 1'b1;
  end

  // Monitor: pops on the first cycle of each result, then checks hold stability.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        seen[k] = 1'b0;
      end else if (ov[k]) begin
        if (!seen[k]) begin
          mon_got = 1'b0;
          if (k == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); mon_got = 1'b1; end
          else if (k == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); mon_got = 1'b1; end
          chk("expected_pending", k, 32'(mon_got), 32'd1);
          if (mon_got) begin
            chk("gt", k, 32'(gt[k]), 32'(cur[k].gt));
            chk("eq", k, 32'(eq[k]), 32'(cur[k].eq));
            chk("lt", k, 32'(lt[k]), 32'(cur[k].lt));
            chk("result", k, 32'(res[k]), 32'(cur[k].res));
            chk("latency", k, 32'(cyc - cur[k].t_acc), 32'(cur[k].lat));
          end
          seen[k] = 1'b1;
        end else begin
          chk("hold_gt", k, 32'(gt[k]), 32'(cur[k].gt));
          chk("hold_eq", k, 32'(eq[k]), 32'(cur[k].eq));
          chk("hold_lt", k, 32'(lt[k]), 32'(cur[k].lt));
          chk("hold_result", k, 32'(res[k]), 32'(cur[k].res));
          chk("hold_in_ready", k, 32'(in_ready[k]), 32'd0);
        end
        if (out_ready) seen[k] = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                       input logic [2:0] iop, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!(in_ready[0] && in_ready[1]) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 0, 32'(n < 300), 32'd1);
    a = ia; b = ib; is_signed = s; op = iop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    is_signed = 1'($urandom); op = 3'($urandom);
    if (push) begin
      e = model(ia, ib, s, iop);
      e.t_acc = cyc;
      q0.push_back(e);
      e.lat = NCHUNK;
      q1.push_back(e);
    end
    n_vec++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && in_ready[0] && in_ready[1]) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 0, 32'(n < 500), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_valid"}, k, 32'(ov[k]), 32'd0);
      chk({name, "_gt"}, k, 32'(gt[k]), 32'd0);
      chk({name, "_eq"}, k, 32'(eq[k]), 32'd0);
      chk({name, "_lt"}, k, 32'(lt[k]), 32'd0);
      chk({name, "_result"}, k, 32'(res[k]), 32'd0);
      chk({name, "_in_ready"}, k, 32'(in_ready[k]), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    issue(8'hC5, 8'h3A, 1'b0, CMP_GE, 1'b1);
    issue(8'hC5, 8'h3A, 1'b1, CMP_GE, 1'b1);
    issue(8'h5A, 8'h5A, 1'b0, CMP_EQ, 1'b1);
    issue(8'h5A, 8'h5A, 1'b0, CMP_NE, 1'b1);
    issue(8'h81, 8'h80, 1'b0, CMP_GT, 1'b1);
    issue(8'h80, 8'h7F, 1'b1, CMP_LT, 1'b1);
    issue(8'h80, 8'h7F, 1'b0, CMP_GT, 1'b1);
    issue(8'h7F, 8'h80, 1'b1, CMP_LE, 1'b0 ? 1'b0 : 1'b1);
    drain();

    // Backpressure: hold out_ready low for five cycles in DONE.
    hold_low = 1'b1;
    issue(8'h5A, 8'h5A, 1'b0, CMP_EQ, 1'b1);
    n = 0;
    while (!(ov[0] && ov[1]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_timeout", 0, 32'(n < 50), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("bp_valid_held", k, 32'(ov[k]), 32'd1);
        chk("bp_in_ready_low", k, 32'(in_ready[k]), 32'd0);
      end
    end
    hold_low = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("bp_release_in_ready", k, 32'(in_ready[k]), 32'd1);
      chk("bp_release_valid", k, 32'(ov[k]), 32'd0);
    end
    drain();

    // Leave nonzero flags behind, then reset in the middle of RUN.
    issue(8'hFF, 8'h00, 1'b0, CMP_GT, 1'b1);
    drain();
    issue(8'h01, 8'h02, 1'b0, CMP_LT, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_outputs_zero("midrun_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) chk("no_valid_after_reset", k, 32'(ov[k]), 32'd0);
    end
    issue(8'h10, 8'h0F, 1'b0, CMP_GT, 1'b1);
    issue(8'h10, 8'h0F, 1'b0, 3'd6, 1'b1);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 8'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = ra ^ 8'h80;
      endcase
      issue(ra, rb, 1'($urandom), 3'($urandom), 1'b1);
    end
    drain();

    chk("leftover_q0", 0, 32'(q0.size()), 32'd0);
    chk("leftover_q1", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_cmp.md
Name: seq_magnitude_cmp

Overview:
- Multi-cycle, parametrised magnitude comparator for the Mini-ALU compare path.
- Takes two WIDTH-bit operands through a valid/ready handshake. Compares them CHUNK bits per cycle, MSB chunk first, with optional early exit.
- Returns registered gt/eq/lt flags and a single result bit for a selectable relational op, in signed or unsigned mode.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- EARLY_EXIT, 1, 1 = finish on the first unequal chunk; 0 = always scan all NCHUNK chunks (fixed latency).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare.
- op  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  consumer accepts result.
- a_gt_b  out  1  A > B.
- a_eq_b  out  1  A == B.
- a_lt_b  out  1  A < B.
- result  out  1  op applied to the flags; 0 for reserved ops.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; the clock/reset ports are clk and reset.
- Reset values: state IDLE; out_valid, a_gt_b, a_eq_b, a_lt_b and result all 0; chunk index 0.
- States:
  - IDLE: in_ready=1. On in_valid, register a, b, op and go to RUN with idx=NCHUNK-1. When is_signed=1, invert the MSB of both captured operands, then compare unsigned.
  - RUN: compare chunk idx of the captured A and B.
    - EARLY_EXIT=1: chunk greater -> gt, go DONE; chunk less -> lt, go DONE; equal with idx==0 -> eq, go DONE; equal otherwise -> idx-1.
    - EARLY_EXIT=0: latch the first unequal chunk's direction, continue to idx==0, then go DONE. Result equals the EARLY_EXIT=1 result.
  - DONE: out_valid=1 and the flags/result are registered and stable. On out_ready, go to IDLE and clear out_valid. Flags hold their last values until the next DONE.
- Exactly one of gt/eq/lt is set in DONE.
- Latency: acceptance edge T0; the chunk examined in cycle k is registered at edge Tk.
  - out_valid goes high after edge Tj, where j = number of chunks examined (1..NCHUNK).
  - EARLY_EXIT=0 gives j = NCHUNK always.
- Back-to-back: no overlap. in_ready stays low from acceptance until the cycle after the DONE->IDLE handshake.
- out_ready held high in DONE: out_valid lasts exactly one cycle.
- Operand inputs are don't-care outside the IDLE acceptance cycle; changes during RUN do not affect the result.
- Reset asserted mid-RUN or in DONE: the operation is dropped, the block returns to IDLE with outputs 0, and no out_valid pulse occurs.
- Signed extremes: signed 0x80 vs 0x7F (WIDTH=8) gives lt; unsigned gives gt.

Decomposition:
- Shared Mini-ALU package/header holds:
  - op encoding constants: CMP_EQ..CMP_GE.
  - FSM state encodings: IDLE/RUN/DONE.
- One natural combinational sub-module: chunk_cmp.
  - Inputs: CHUNK-wide x, y. Outputs: gt, eq.
  - Instantiated once on the mux-selected chunk.
- FSM, index counter and op decode stay in seq_magnitude_cmp.

Test Plan:
- WIDTH=8, CHUNK=2, unsigned, a=0xC5, b=0x3A, op=GE -> gt=1, result=1, out_valid one cycle after acceptance (top chunk decides).
- Same operands, is_signed=1, op=GE -> lt=1 (-59 < 58), result=0, one cycle latency.
- a=0x5A, b=0x5A, op=EQ, then op=NE -> eq=1; result 1 then 0; out_valid after 4 cycles each.
- a=0x81, b=0x80, op=GT, EARLY_EXIT=1 -> result=1 after 4 cycles. Rerun a=0xC5, b=0x3A with EARLY_EXIT=0 -> still 4 cycles, gt=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, flags and result stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset pulse during RUN (a=0x01, b=0x02) -> outputs 0 immediately, no out_valid. After release a new op (0x10 vs 0x0F, GT) completes with result=1; op=6 returns result=0.
